bullcow_entry: RTL and testbench

Player-side entry front end for the Bulls & Cows game. It synchronises and debounces the raw confirm pushbutton and captures the four hex digits on `SW`. It rejects entries with repeated digits and delivers each accepted 4-digit code to the game FSM as a single-cycle `enter` pulse with a stable `guess` bus. It sits between the board I/O (switches and button) and the game FSM's `enter`/`guess` inputs, and serves both secret setup and guessing.

---
 rtl/bullcow_entry.sv | 85 ++++++++
 tb/tb_bullcow_entry.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/bullcow_entry.sv
// bullcow_entry: debounced confirm button, switch capture, repeated-digit rejection and enter handshake
module bullcow_entry #(
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [15:0]     SW,
   input  logic            btn_enter,
   input  logic            ready,
   output logic            enter,
   output logic [3:0][3:0] guess,
   output logic            reject,
   output logic [7:0]      entry_count,
   output logic            busy
);

   localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;

   typedef enum logic [2:0] {IDLE, CHECK, WAIT_READY, FIRE, WAIT_RELEASE} state_t;

   state_t state, next;
   logic [1:0] sync;
   logic btn_s, deb, deb_q, press, distinct;
   logic [CW-1:0] cnt;

   assign btn_s = sync[1];
   assign press = deb & ~deb_q;
   assign distinct = guess[0] != guess[1] && guess[0] != guess[2] && guess[0] != guess[3] &&
                     guess[1] != guess[2] && guess[1] != guess[3] && guess[2] != guess[3];

   // two-flop synchroniser for the raw pushbutton
   always_ff @(posedge clock or posedge reset)
      if (reset) sync <= '0;
      else sync <= {sync[0], btn_enter};

   // debouncer: the level only changes after a full run of stable disagreeing samples
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         deb   <= 1'b0;
         deb_q <= 1'b0;
         cnt   <= '0;
      end else begin
         deb_q <= deb;
         if (btn_s == deb) cnt <= '0;
         else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            deb <= btn_s;
            cnt <= '0;
         end else cnt <= cnt + 1'b1;
      end

   // state register
   always_ff @(posedge clock or posedge reset)
      if (reset) state <= IDLE;
      else state <= next;

   // next-state decode
   always_comb begin
      next = state;
      case (state)
         IDLE:         next = press ? CHECK : IDLE;
         CHECK:        next = distinct ? WAIT_READY : WAIT_RELEASE;
         WAIT_READY:   next = ready ? FIRE : WAIT_READY;
         FIRE:         next = WAIT_RELEASE;
         WAIT_RELEASE: next = deb ? WAIT_RELEASE : IDLE;
         default:      next = IDLE;
      endcase
   end

   // registered outputs decoded from the next state, plus capture and delivery count
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         enter       <= 1'b0;
         reject      <= 1'b0;
         busy        <= 1'b0;
         guess       <= '0;
         entry_count <= '0;
      end else begin
         enter  <= next == FIRE;
         reject <= state == CHECK && !distinct;
         busy   <= next != IDLE;
         if (state == IDLE && press) guess <= SW;
         if (next == FIRE) entry_count <= entry_count + 1'b1;
      end

endmodule

// File: tb/tb_bullcow_entry.sv
// tb_bullcow_entry: directed vector bench for bullcow_entry with DEBOUNCE_CYCLES=4
module tb_bullcow_entry;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic [15:0] SW = '0;
   logic btn_enter = 1'b0;
   logic ready = 1'b1;
   logic enter, reject, busy;
   logic [3:0][3:0] guess;
   logic [7:0] entry_count;

   int n_cmp = 0;
   int n_bad = 0;

   bullcow_entry #(.DEBOUNCE_CYCLES(4)) dut (
      .clock(clock), .reset(reset), .SW(SW), .btn_enter(btn_enter), .ready(ready),
      .enter(enter), .guess(guess), .reject(reject), .entry_count(entry_count), .busy(busy)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [15:0] sw;
      int          enter_at;
      int          reject_at;
      logic [7:0]  count;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      @(negedge clock);
   endtask

   // press at a negedge, observe 20 edges, release, observe 20 more edges
   task automatic run_press(input logic [15:0] sw, output int enter_at, output int reject_at,
                            output int n_enter, output int n_reject, output int idle_at);
      enter_at = -1; reject_at = -1; n_enter = 0; n_reject = 0; idle_at = -1;
      SW = sw;
      btn_enter = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (enter) begin n_enter++; if (enter_at < 0) enter_at = k; end
         if (reject) begin n_reject++; if (reject_at < 0) reject_at = k; end
      end
      btn_enter = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (enter) n_enter++;
         if (reject) n_reject++;
         if (!busy && idle_at < 0) idle_at = k;
      end
   endtask

   initial begin
      int ea, ra, ne, nr, ia;
      vecs[0] = '{16'h4321,  9, -1, 8'd1};
      vecs[1] = '{16'h1231, -1,  8, 8'd1};
      vecs[2] = '{16'h0123,  9, -1, 8'd2};
      vecs[3] = '{16'h0000, -1,  8, 8'd2};
      vecs[4] = '{16'hFEDC,  9, -1, 8'd3};
      vecs[5] = '{16'h5566, -1,  8, 8'd3};
      vecs[6] = '{16'h9807,  9, -1, 8'd4};
      vecs[7] = '{16'h1021, -1,  8, 8'd4};
      vecs[8] = '{16'hA0B1,  9, -1, 8'd5};

      tick(); tick();
      check("reset_enter", {31'd0, enter}, 0);
      check("reset_reject", {31'd0, reject}, 0);
      check("reset_busy", {31'd0, busy}, 0);
      check("reset_guess", {16'd0, guess}, 0);
      check("reset_count", {24'd0, entry_count}, 0);
      reset = 1'b0;
      tick();

      for (int i = 0; i < 9; i++) begin
         run_press(vecs[i].sw, ea, ra, ne, nr, ia);
         check($sformatf("v%0d_enter_at", i), ea, vecs[i].enter_at);
         check($sformatf("v%0d_reject_at", i), ra, vecs[i].reject_at);
         check($sformatf("v%0d_n_enter", i), ne, vecs[i].enter_at > 0 ? 1 : 0);
         check($sformatf("v%0d_n_reject", i), nr, vecs[i].reject_at > 0 ? 1 : 0);
         check($sformatf("v%0d_guess", i), {16'd0, guess}, {16'd0, vecs[i].sw});
         check($sformatf("v%0d_count", i), {24'd0, entry_count}, {24'd0, vecs[i].count});
         check($sformatf("v%0d_idle_at", i), ia, 7);
      end

      // bounce then long hold: exactly one delivery
      SW = 16'h2468;
      ne = 0;
      for (int p = 0; p < 3; p++) begin
         btn_enter = 1'b1; tick(); tick();
         btn_enter = 1'b0; tick(); tick();
      end
      check("bounce_no_busy", {31'd0, busy}, 0);
      btn_enter = 1'b1;
      for (int k = 0; k < 110; k++) begin tick(); if (enter) ne++; end
      btn_enter = 1'b0;
      for (int k = 0; k < 20; k++) begin tick(); if (enter) ne++; end
      check("bounce_n_enter", ne, 1);
      check("bounce_count", {24'd0, entry_count}, 6);
      check("bounce_idle", {31'd0, busy}, 0);

      // ready held low: code waits, later SW change and release are ignored
      ready = 1'b0;
      SW = 16'h4321;
      btn_enter = 1'b1;
      for (int k = 0; k < 8; k++) tick();
      ne = 0; nr = 0;
      for (int k = 0; k < 20; k++) begin
         if (k == 5) SW = 16'h5678;
         if (k == 10) btn_enter = 1'b0;
         tick();
         if (enter) ne++;
         if (!busy) nr++;
      end
      check("wait_no_enter", ne, 0);
      check("wait_busy_drops", nr, 0);
      ready = 1'b1;
      tick();
      check("wait_enter", {31'd0, enter}, 1);
      check("wait_guess", {16'd0, guess}, 16'h4321);
      check("wait_count", {24'd0, entry_count}, 7);
      tick();
      check("wait_enter_one", {31'd0, enter}, 0);
      tick(); tick();
      check("wait_idle", {31'd0, busy}, 0);

      // wrap: 256 deliveries from reset return the count to 0
      reset = 1'b1; tick(); reset = 1'b0; tick();
      for (int i = 0; i < 256; i++) run_press(16'h3210, ea, ra, ne, nr, ia);
      check("wrap_256", {24'd0, entry_count}, 0);
      run_press(16'h3210, ea, ra, ne, nr, ia);
      check("wrap_257", {24'd0, entry_count}, 1);

      // reset while waiting for ready aborts the pending code
      ready = 1'b0;
      SW = 16'h4321;
      btn_enter = 1'b1;
      for (int k = 0; k < 12; k++) tick();
      check("abort_busy_before", {31'd0, busy}, 1);
      #2 reset = 1'b1;
      #1;
      check("abort_enter", {31'd0, enter}, 0);
      check("abort_reject", {31'd0, reject}, 0);
      check("abort_busy", {31'd0, busy}, 0);
      check("abort_guess", {16'd0, guess}, 0);
      check("abort_count", {24'd0, entry_count}, 0);
      btn_enter = 1'b0;
      tick(); tick();
      reset = 1'b0;
      ready = 1'b1;
      ne = 0;
      for (int k = 0; k < 30; k++) begin tick(); if (enter || busy) ne++; end
      check("abort_no_enter", ne, 0);
      run_press(16'h8765, ea, ra, ne, nr, ia);
      check("after_abort_enter_at", ea, 9);
      check("after_abort_count", {24'd0, entry_count}, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
